mod_exp_engine: RTL and testbench

Parametrised modular exponentiation engine computing result = base^expo mod modulus for NBITS-wide operands. It is the successor to the fixed 256-bit power unit and serves the same place in the RSA datapath. Unlike that unit, it needs no precomputed 2^k mod N constant and no external multiplier instances. It uses two internal bit-serial interleaved modular multipliers, reduces an out-of-range base itself, has a ready/start/done handshake, flags modulus = 0, and stops after the exponent's highest set bit.

---
 rtl/mod_exp_engine.sv | 189 ++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: result = base^expo mod modulus using the right-to-left
// binary method on two bit-serial interleaved modular multipliers (units R and S).
module mod_exp_engine #(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [NBITS-1:0] base,
  input  logic [NBITS-1:0] expo,
  input  logic [NBITS-1:0] modulus,
  output logic [NBITS-1:0] result,
  output logic             done,
  output logic             err
);

  localparam int               CW       = $clog2(NBITS + 1);
  localparam logic [CW-1:0]    LAST_BIT = CW'(NBITS - 1);
  localparam logic [NBITS-1:0] ONE      = NBITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REDUCE,
    S_EXAM,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] e_q, e_d;
  logic [NBITS-1:0] n_q, n_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [NBITS-1:0] pr_q, pr_d;
  logic [NBITS-1:0] ps_q, ps_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NBITS-1:0] b_shift;
  logic [NBITS-1:0] x_r;
  logic [NBITS-1:0] step_r;
  logic [NBITS-1:0] step_s;
  logic             y_bit;

  // One MSB-first iteration of P*X*Y mod N; two extra bits hold 2P and P+X before reduction.
  function automatic logic [NBITS-1:0] mod_step(input logic [NBITS-1:0] p,
                                                input logic [NBITS-1:0] x,
                                                input logic [NBITS-1:0] n,
                                                input logic             y);
    logic [NBITS+1:0] acc;
    logic [NBITS+1:0] n_w;
    // NOTE: blocking assignments here model a combinational chain; the value flows
    // through acc in order within one evaluation.
    n_w = {2'b00, n};
    acc = {1'b0, p, 1'b0};
    if (acc >= n_w) acc = acc - n_w;
    if (y) begin
      acc = acc + {2'b00, x};
      if (acc >= n_w) acc = acc - n_w;
    end
    return acc[NBITS-1:0];
  endfunction

  // Unit R doubles as the base reducer (X=1) during REDUCE; both units scan bits of B.
  always_comb begin
    b_shift = b_q >> cnt_q;
    y_bit   = b_shift[0];
    x_r     = (state_q == S_REDUCE) ? ONE : r_q;
    step_r  = mod_step(pr_q, x_r, n_q, y_bit);
    step_s  = mod_step(ps_q, b_q, n_q, y_bit);
  end

  always_comb begin
    // NOTE: every signal written here gets its hold value first so no path infers a latch.
    state_d  = state_q;
    b_d      = b_q;
    e_d      = e_q;
    n_d      = n_q;
    r_d      = r_q;
    pr_d     = pr_q;
    ps_d     = ps_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d     = base;
          e_d     = expo;
          n_d     = modulus;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // err and result are only ever updated on entry to DONE, so they stay stable otherwise.
        if (n_q == '0) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          r_d     = (n_q == ONE) ? '0 : ONE;
          pr_d    = '0;
          cnt_d   = LAST_BIT;
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        pr_d = step_r;
        if (cnt_q == '0) begin
          b_d     = step_r;
          pr_d    = '0;
          state_d = S_EXAM;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EXAM: begin
        if (e_q == '0) begin
          result_d = r_q;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          pr_d    = '0;
          ps_d    = '0;
          cnt_d   = LAST_BIT;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        pr_d = step_r;
        ps_d = step_s;
        if (cnt_q == '0) begin
          if (e_q[0]) r_d = step_r;
          b_d     = step_s;
          e_d     = e_q >> 1;
          pr_d    = '0;
          ps_d    = '0;
          state_d = S_EXAM;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state, including the wide operand registers, is reset so an abandoned
    // operation leaves nothing behind.
    if (rst) begin
      state_q  <= S_IDLE;
      b_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      pr_q     <= '0;
      ps_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      e_q      <= e_d;
      n_q      <= n_d;
      r_q      <= r_d;
      pr_q     <= pr_d;
      ps_q     <= ps_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Bench for mod_exp_engine: 8-, 32- and 256-bit instances checked against a plain
// square-and-multiply model and the closed-form latency.
module tb_mod_exp_engine;

  localparam int NU = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [255:0]      base_s, expo_s, mod_s;
  logic [NU-1:0]     start_v, ready_w, done_w, err_w;
  logic [7:0]        res8;
  logic [31:0]       res32;
  logic [255:0]      res256;
  logic [255:0]      res_w [NU];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_exp_engine #(.NBITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .ready(ready_w[0]),
    .base(base_s[7:0]), .expo(expo_s[7:0]), .modulus(mod_s[7:0]),
    .result(res8), .done(done_w[0]), .err(err_w[0])
  );

  mod_exp_engine #(.NBITS(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start_v[1]), .ready(ready_w[1]),
    .base(base_s[31:0]), .expo(expo_s[31:0]), .modulus(mod_s[31:0]),
    .result(res32), .done(done_w[1]), .err(err_w[1])
  );

  mod_exp_engine #(.NBITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .start(start_v[2]), .ready(ready_w[2]),
    .base(base_s), .expo(expo_s), .modulus(mod_s),
    .result(res256), .done(done_w[2]), .err(err_w[2])
  );

  assign res_w[0] = {248'b0, res8};
  assign res_w[1] = {224'b0, res32};
  assign res_w[2] = res256;

  function automatic int width_of(input int w);
    case (w)
      0:       return 8;
      1:       return 32;
      default: return 256;
    endcase
  endfunction

  function automatic logic [255:0] width_mask(input int nb);
    logic [255:0] m;
    if (nb >= 256) m = '1;
    else m = (256'd1 << nb) - 256'd1;
    return m;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: plain square-and-multiply with full-width products and the % operator.
  function automatic logic [255:0] ref_modexp(input logic [255:0] b, input logic [255:0] e,
                                              input logic [255:0] m, input int nb);
    logic [511:0] r, x, mm;
    if (m == '0) return '0;
    mm = {256'b0, m};
    r  = 512'd1 % mm;
    x  = {256'b0, b} % mm;
    for (int i = 0; i < nb; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[255:0];
  endfunction

  function automatic int bit_len(input logic [255:0] e);
    int l = 0;
    for (int i = 0; i < 256; i++) if (e[i]) l = i + 1;
    return l;
  endfunction

  function automatic int exp_latency(input logic [255:0] e, input logic [255:0] m, input int nb);
    if (m == '0) return 2;
    return nb + 3 + bit_len(e) * (nb + 1);
  endfunction

  // Waits for done on unit w; cyc counts negedges since the accepting edge (cycle number).
  task automatic wait_done(input int w, output int cyc);
    int limit;
    limit = width_of(w) * (width_of(w) + 2) + 10;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_w[w] && cyc < limit);
    checks++;
    if (!done_w[w]) begin
      errors++;
      $display("FAIL timeout unit%0d: no done after %0d cycles, required within %0d", w, cyc, limit);
    end
  endtask

  // Issues one operation, scrambles the inputs after acceptance, returns result/err/latency.
  task automatic do_op(input int w, input logic [255:0] b, input logic [255:0] e,
                       input logic [255:0] m, output logic [255:0] res, output logic er,
                       output int lat);
    @(negedge clk);
    base_s     = b;
    expo_s     = e;
    mod_s      = m;
    start_v[w] = 1'b1;
    @(posedge clk);
    #1;
    start_v[w] = 1'b0;
    base_s     = rand256();
    expo_s     = rand256();
    mod_s      = rand256();
    wait_done(w, lat);
    res = res_w[w];
    er  = err_w[w];
    @(negedge clk);
    checks++;
    if (done_w[w] !== 1'b0 || ready_w[w] !== 1'b1) begin
      errors++;
      $display("FAIL pulse unit%0d: done=%b ready=%b after done, required done=0 ready=1",
               w, done_w[w], ready_w[w]);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    start_v = '0;
    base_s  = '0;
    expo_s  = '0;
    mod_s   = '0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < NU; w++) begin
      checks++;
      if ({ready_w[w], done_w[w], err_w[w]} !== 3'b100 || res_w[w] !== '0) begin
        errors++;
        $display("FAIL reset unit%0d: ready/done/err=%b%b%b result=%0h, required 100 and 0",
                 w, ready_w[w], done_w[w], err_w[w], res_w[w]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [255:0] res;
    logic er;
    int lat;
    do_op(0, 256'd3, 256'd5, 256'd7, res, er, lat);
    checks++;
    if (res !== 256'd5 || er !== 1'b0) begin
      errors++;
      $display("FAIL basic: result=%0d err=%b, required 5 and 0", res, er);
    end
    checks++;
    if (lat != 38) begin
      errors++;
      $display("FAIL basic latency: done at cycle %0d, required 38", lat);
    end
  endtask

  task automatic test_boundaries;
    int bv [3], ev [3], mv [3], rv [3], lv [3];
    logic [255:0] res;
    logic er;
    int lat;
    bv = '{10, 5, 5};
    ev = '{3, 0, 0};
    mv = '{7, 7, 1};
    rv = '{6, 1, 0};
    lv = '{29, 11, 11};
    for (int k = 0; k < 3; k++) begin
      do_op(0, 256'(bv[k]), 256'(ev[k]), 256'(mv[k]), res, er, lat);
      checks++;
      if (res !== 256'(rv[k]) || er !== 1'b0 || lat != lv[k]) begin
        errors++;
        $display("FAIL boundary %0d^%0d mod %0d: result=%0d err=%b cycle=%0d, required %0d 0 %0d",
                 bv[k], ev[k], mv[k], res, er, lat, rv[k], lv[k]);
      end
    end
  endtask

  task automatic test_mod_zero;
    logic [255:0] res;
    logic er;
    int lat;
    do_op(0, 256'd4, 256'd9, 256'd0, res, er, lat);
    checks++;
    if (res !== '0 || er !== 1'b1 || lat != 2) begin
      errors++;
      $display("FAIL mod_zero: result=%0d err=%b cycle=%0d, required 0 1 2", res, er, lat);
    end
    do_op(0, 256'd2, 256'd7, 256'd11, res, er, lat);
    checks++;
    if (res !== 256'd7 || er !== 1'b0 || lat != 38) begin
      errors++;
      $display("FAIL err_clear: result=%0d err=%b cycle=%0d, required 7 0 38", res, er, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [255:0] res;
    logic er;
    int lat;
    logic seen;
    @(negedge clk);
    base_s     = 256'd3;
    expo_s     = 256'd255;
    mod_s      = 256'd251;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (res_w[0] !== 256'd7 || err_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL result_hold: mid-op result=%0d err=%b, required previous 7 0", res_w[0], err_w[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ready_w[0], done_w[0], err_w[0]} !== 3'b100 || res_w[0] !== '0) begin
      errors++;
      $display("FAIL async_reset: ready/done/err=%b%b%b result=%0d, required 100 and 0",
               ready_w[0], done_w[0], err_w[0], res_w[0]);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_w[0]) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_w[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abandon: done=%b seen after reset, required 0", seen);
    end
    do_op(0, 256'd3, 256'd255, 256'd251, res, er, lat);
    checks++;
    if (res !== ref_modexp(256'd3, 256'd255, 256'd251, 8) || er !== 1'b0 || lat != 83) begin
      errors++;
      $display("FAIL rerun: result=%0d err=%b cycle=%0d, required %0d 0 83",
               res, er, lat, ref_modexp(256'd3, 256'd255, 256'd251, 8));
    end
  endtask

  task automatic test_handshake;
    int lat;
    logic bad;
    // A start pulse while busy must be dropped.
    @(negedge clk);
    base_s = 256'd3; expo_s = 256'd5; mod_s = 256'd7;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_fall: ready=%b in cycle 1, required 0", ready_w[0]);
    end
    repeat (9) @(negedge clk);
    base_s = 256'd2; expo_s = 256'd7; mod_s = 256'd11;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, lat);
    lat += 11;
    checks++;
    if (res_w[0] !== 256'd5 || lat != 38) begin
      errors++;
      $display("FAIL busy_start: result=%0d cycle=%0d, required 5 38", res_w[0], lat);
    end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_w[0] || !ready_w[0]) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL not_queued: busy start started an op (flag=%b), required 0", bad);
    end
    // start held high across done is accepted again at the first IDLE edge.
    @(negedge clk);
    base_s = 256'd3; expo_s = 256'd5; mod_s = 256'd7;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    base_s = 256'd10; expo_s = 256'd3; mod_s = 256'd7;
    wait_done(0, lat);
    checks++;
    if (res_w[0] !== 256'd5 || lat != 38) begin
      errors++;
      $display("FAIL hold_first: result=%0d cycle=%0d, required 5 38", res_w[0], lat);
    end
    @(negedge clk);
    checks++;
    if (ready_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: ready=%b done=%b after done, required 1 0", ready_w[0], done_w[0]);
    end
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, lat);
    checks++;
    if (res_w[0] !== 256'd6 || lat != 29) begin
      errors++;
      $display("FAIL hold_second: result=%0d cycle=%0d, required 6 29", res_w[0], lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int w, input int count, input int ebits);
    logic [255:0] b, e, m, res, want;
    logic er;
    int lat, nb;
    nb = width_of(w);
    for (int k = 0; k < count; k++) begin
      b = rand256() & width_mask(nb);
      e = rand256() & width_mask(ebits);
      case ($urandom_range(0, 15))
        0:       m = '0;
        1:       m = 256'd1;
        2:       m = rand256() & width_mask(nb) & ~256'd1;
        default: m = rand256() & width_mask(nb);
      endcase
      do_op(w, b, e, m, res, er, lat);
      want = ref_modexp(b, e, m, nb);
      checks++;
      if (res !== want) begin
        errors++;
        $display("FAIL random%0d result: got %0h, required %0h (b=%0h e=%0h m=%0h)",
                 nb, res, want, b, e, m);
      end
      checks++;
      if (er !== (m == '0)) begin
        errors++;
        $display("FAIL random%0d err: got %b, required %b", nb, er, (m == '0));
      end
      checks++;
      if (lat != exp_latency(e, m, nb)) begin
        errors++;
        $display("FAIL random%0d latency: cycle %0d, required %0d", nb, lat, exp_latency(e, m, nb));
      end
    end
  endtask

  task automatic test_wide;
    logic [255:0] b, e, m, res, want;
    logic er;
    int lat;
    b = rand256();
    m = rand256() | 256'd1;
    e = 256'd65537;
    do_op(2, b, e, m, res, er, lat);
    want = ref_modexp(b, e, m, 256);
    checks++;
    if (res !== want || er !== 1'b0 || lat != 4628) begin
      errors++;
      $display("FAIL f4_256: result=%0h err=%b cycle=%0d, required %0h 0 4628", res, er, lat, want);
    end
    b = rand256() & width_mask(32);
    m = (rand256() & width_mask(32)) | 256'd2;
    e = width_mask(32);
    do_op(1, b, e, m, res, er, lat);
    want = ref_modexp(b, e, m, 32);
    checks++;
    if (res !== want || er !== 1'b0 || lat != 1091) begin
      errors++;
      $display("FAIL all_ones_32: result=%0h err=%b cycle=%0d, required %0h 0 1091", res, er, lat, want);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundaries;
    test_mod_zero;
    test_reset_mid;
    test_handshake;
    test_random(0, 150, 8);
    test_random(1, 15, 32);
    test_random(2, 4, 12);
    test_wide;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
